// File: rtl/adder_tree_pkg.sv
// Shared widths and arithmetic helpers for the pipelined product adder tree.
package adder_tree_pkg;

    localparam int N_IN_D   = 64;
    localparam int IN_W_D   = 17;
    localparam int LEVELS_D = 2;
    localparam int OUT_W_D  = 19;
    localparam int ACC_W_D  = 24;

    typedef logic signed [63:0] wide_t;

    typedef struct packed {
        logic first;
        logic last;
    } ctrl_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int lvl_w(input int in_w, input int k);
        return in_w + k;
    endfunction

    function automatic int n_out(input int n_in, input int levels);
        return n_in >> levels;
    endfunction

    function automatic wide_t sat_hi(input int out_w);
        return (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat(input wide_t value, input int in_w,
                                  input int out_w);
        wide_t hi;
        wide_t lo;
        hi = sat_hi(out_w);
        lo = -hi - wide_t'(1);
        if (out_w >= in_w) return value;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    function automatic logic sat_hit(input wide_t value, input int in_w,
                                     input int out_w);
        wide_t hi;
        wide_t lo;
        hi = sat_hi(out_w);
        lo = -hi - wide_t'(1);
        if (out_w >= in_w) return 1'b0;
        return (value > hi) || (value < lo);
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise reduction level: W-bit pairs in, W+1-bit sums out.
module adder_tree_level
    import adder_tree_pkg::*;
#(
    parameter int N_PAIRS = 32,
    parameter int W       = 17
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       v_in,
    input  logic [2*N_PAIRS*W-1:0]     d_in,
    output logic                       v_out,
    output logic [N_PAIRS*(W+1)-1:0]   d_out
);

    logic [N_PAIRS*(W+1)-1:0] w_sum;
    logic [N_PAIRS*(W+1)-1:0] r_d;
    logic                     r_v;

    for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
        logic [W:0] w_a;
        logic [W:0] w_b;
        assign w_a = {d_in[2*p*W+W-1], d_in[2*p*W +: W]};
        assign w_b = {d_in[(2*p+1)*W+W-1], d_in[(2*p+1)*W +: W]};
        assign w_sum[p*(W+1) +: W+1] = w_a + w_b;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else if (enable) begin
            r_v <= v_in;
            if (v_in) r_d <= w_sum;
        end
    end

    assign v_out = r_v;
    assign d_out = r_d;

endmodule

// File: rtl/adder_tree_pipelined.sv
// Pipelined signed adder tree with saturating lane outputs.
// Define ADDER_TREE_ACC_EN to add per-lane group accumulation (in_first/in_last).
module adder_tree_pipelined
    import adder_tree_pkg::*;
#(
    parameter int N_IN   = N_IN_D,
    parameter int IN_W   = IN_W_D,
    parameter int LEVELS = LEVELS_D,
    parameter int OUT_W  = OUT_W_D,
    parameter int ACC_W  = ACC_W_D
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             in_valid,
    input  logic [N_IN*IN_W-1:0]             data_in,
`ifdef ADDER_TREE_ACC_EN
    input  logic                             in_first,
    input  logic                             in_last,
`endif
    output logic                             out_valid,
    output logic [(N_IN>>LEVELS)*OUT_W-1:0]  sum_out,
    output logic                             sum_sat
);

    localparam int N_OUT = n_out(N_IN, LEVELS);
    localparam int TW    = lvl_w(IN_W, LEVELS);
`ifdef ADDER_TREE_ACC_EN
    localparam int VAL_W = ACC_W;
`else
    localparam int VAL_W = TW;
`endif

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int NP = N_IN >> k;
        localparam int WI = lvl_w(IN_W, k - 1);
        logic                  w_vi;
        logic [2*NP*WI-1:0]    w_di;
        logic                  w_vo;
        logic [NP*(WI+1)-1:0]  w_do;
        if (k == 1) begin : g_src
            assign w_vi = in_valid;
            assign w_di = data_in;
        end else begin : g_src
            assign w_vi = g_lvl[k-1].w_vo;
            assign w_di = g_lvl[k-1].w_do;
        end
        adder_tree_level #(
            .N_PAIRS (NP),
            .W       (WI)
        ) u_level (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable),
            .v_in    (w_vi),
            .d_in    (w_di),
            .v_out   (w_vo),
            .d_out   (w_do)
        );
    end

    logic [N_OUT*TW-1:0]     w_tree;
    logic                    w_vfin;
    logic                    w_load;
    wide_t                   w_val [N_OUT];
    logic [N_OUT*OUT_W-1:0]  w_sum_d;
    logic [N_OUT-1:0]        w_clamp;

    assign w_tree = g_lvl[LEVELS].w_do;
    assign w_vfin = g_lvl[LEVELS].w_vo;

`ifdef ADDER_TREE_ACC_EN
    ctrl_t                   r_ctl [1:LEVELS];
    logic [N_OUT*ACC_W-1:0]  r_acc;
    logic [N_OUT*ACC_W-1:0]  w_acc_new;
    logic                    r_open;
    logic                    w_first;
    logic                    w_last;

    // first/last travel with their beat so they line up with the tree sum
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 1; k <= LEVELS; k++) r_ctl[k] <= '0;
        end else if (enable) begin
            r_ctl[1] <= '{first: in_first, last: in_last};
            for (int k = 2; k <= LEVELS; k++) r_ctl[k] <= r_ctl[k-1];
        end
    end

    assign w_first = r_ctl[LEVELS].first;
    assign w_last  = r_ctl[LEVELS].last;
    assign w_load  = w_vfin & w_last;

    always_comb begin
        w_acc_new = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (w_first || !r_open)
                w_acc_new[j*ACC_W +: ACC_W] =
                    ACC_W'(wide_t'(signed'(w_tree[j*TW +: TW])));
            else
                w_acc_new[j*ACC_W +: ACC_W] = r_acc[j*ACC_W +: ACC_W] +
                    ACC_W'(wide_t'(signed'(w_tree[j*TW +: TW])));
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUT; j++)
            w_val[j] = wide_t'(signed'(w_acc_new[j*ACC_W +: ACC_W]));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_acc  <= '0;
            r_open <= 1'b0;
        end else if (enable && w_vfin) begin
            r_acc  <= w_acc_new;
            r_open <= !w_last;
        end
    end
`else
    assign w_load = w_vfin;

    always_comb begin
        for (int j = 0; j < N_OUT; j++)
            w_val[j] = wide_t'(signed'(w_tree[j*TW +: TW]));
    end
`endif

    always_comb begin
        w_sum_d = '0;
        w_clamp = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_sum_d[j*OUT_W +: OUT_W] = OUT_W'(sat(w_val[j], VAL_W, OUT_W));
            w_clamp[j] = sat_hit(w_val[j], VAL_W, OUT_W);
        end
    end

    logic                    r_ov;
    logic [N_OUT*OUT_W-1:0]  r_sum;
    logic                    r_sat;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ov  <= 1'b0;
            r_sum <= '0;
            r_sat <= 1'b0;
        end else if (enable) begin
            r_ov  <= w_load;
            r_sat <= w_load & (|w_clamp);
            if (w_load) r_sum <= w_sum_d;
        end
    end

    assign out_valid = r_ov;
    assign sum_out   = r_sum;
    assign sum_sat   = r_sat;

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Scoreboard bench: exact-width (OUT_W=19) and saturating (OUT_W=17) instances.
module tb_adder_tree_pipelined;

    localparam int N_IN = 64;
    localparam int IN_W = 17;
    localparam int NO   = 16;

    logic                   clk      = 1'b0;
    logic                   rst_n    = 1'b0;
    logic                   en       = 1'b0;
    logic                   in_valid = 1'b0;
    logic [N_IN*IN_W-1:0]   data_in  = '0;
    logic                   va, vb, sa, sb;
    logic [NO*19-1:0]       suma;
    logic [NO*17-1:0]       sumb;
`ifdef ADDER_TREE_ACC_EN
    logic                   in_first = 1'b1;
    logic                   in_last  = 1'b1;
`endif

    always #5 clk = ~clk;

    adder_tree_pipelined #(.OUT_W(19)) u_dut_a (
        .clock     (clk),
        .reset     (rst_n),
        .enable    (en),
        .in_valid  (in_valid),
        .data_in   (data_in),
`ifdef ADDER_TREE_ACC_EN
        .in_first  (in_first),
        .in_last   (in_last),
`endif
        .out_valid (va),
        .sum_out   (suma),
        .sum_sat   (sa)
    );

    adder_tree_pipelined #(.OUT_W(17)) u_dut_b (
        .clock     (clk),
        .reset     (rst_n),
        .enable    (en),
        .in_valid  (in_valid),
        .data_in   (data_in),
`ifdef ADDER_TREE_ACC_EN
        .in_first  (in_first),
        .in_last   (in_last),
`endif
        .out_valid (vb),
        .sum_out   (sumb),
        .sum_sat   (sb)
    );

    typedef struct {
        logic [NO*19-1:0] sum;
        logic             sat;
        int               stamp;
    } ent_t;

    ent_t              qa[$];
    ent_t              qb[$];
    int                total = 0;
    int                bad   = 0;
    int                en_cnt = 0;
    logic              last_en  = 1'b0;
    logic              last_rst = 1'b1;
    logic [NO*19-1:0]  last_a = '0;
    logic [NO*19-1:0]  last_b = '0;

    always @(posedge clk) begin
        last_en  = en & rst_n;
        last_rst = !rst_n;
        if (rst_n && en) en_cnt++;
    end

    task automatic chk(input string nm, input logic [NO*19-1:0] act,
                       input logic [NO*19-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ent_t e;
        if (last_rst) begin
            last_a = '0;
        end else if (last_en) begin
            if (va) begin
                if (qa.size() == 0) begin
                    chk("A_stray_valid", {303'b0, va}, '0);
                end else begin
                    e = qa.pop_front();
                    chk("A_sum", suma, e.sum);
                    chk("A_sat", {303'b0, sa}, {303'b0, e.sat});
                    chk("A_latency", (NO*19)'(en_cnt - e.stamp), 3);
                    last_a = e.sum;
                end
            end else begin
                chk("A_hold", suma, last_a);
                chk("A_idle_sat", {303'b0, sa}, '0);
            end
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (last_rst) begin
            last_b = '0;
        end else if (last_en) begin
            if (vb) begin
                if (qb.size() == 0) begin
                    chk("B_stray_valid", {303'b0, vb}, '0);
                end else begin
                    e = qb.pop_front();
                    chk("B_sum", {32'b0, sumb}, e.sum);
                    chk("B_sat", {303'b0, sb}, {303'b0, e.sat});
                    chk("B_latency", (NO*19)'(en_cnt - e.stamp), 3);
                    last_b = e.sum;
                end
            end else begin
                chk("B_hold", {32'b0, sumb}, last_b);
                chk("B_idle_sat", {303'b0, sb}, '0);
            end
        end
    end

    function automatic logic [N_IN*IN_W-1:0] rep_in(input int v);
        logic [IN_W-1:0] t;
        t = IN_W'(v);
        return {N_IN{t}};
    endfunction

    function automatic logic [NO*19-1:0] rep_a(input int v);
        logic [18:0] t;
        t = 19'(v);
        return {NO{t}};
    endfunction

    function automatic logic [NO*17-1:0] rep_b(input int v);
        logic [16:0] t;
        t = 17'(v);
        return {NO{t}};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [N_IN*IN_W-1:0] d,
                         input logic [NO*19-1:0] ea, input logic xa,
                         input logic [NO*17-1:0] eb, input logic xb);
        ent_t e;
        data_in  = d;
        in_valid = 1'b1;
        e.sum = ea;
        e.sat = xa;
        e.stamp = en_cnt;
        qa.push_back(e);
        e.sum = {32'b0, eb};
        e.sat = xb;
        qb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [N_IN*IN_W-1:0] d_ramp, d_edge;
    logic [NO*19-1:0]     e_ramp_a;
    logic [NO*17-1:0]     e_ramp_b;

    initial begin
        // ramp: element i = i-32, so lane j = 16j-122
        for (int i = 0; i < N_IN; i++) begin
            d_ramp[i*IN_W +: IN_W] = IN_W'(i - 32);
            d_edge[i*IN_W +: IN_W] = (i % 4 == 0) ? 17'd16383 : 17'd16384;
        end
        for (int j = 0; j < NO; j++) begin
            e_ramp_a[j*19 +: 19] = 19'(16*j - 122);
            e_ramp_b[j*17 +: 17] = 17'(16*j - 122);
        end

        en = 1'b1;
        rst_n = 1'b0;
        idle(2);
        chk("reset_valid_a", {303'b0, va}, '0);
        chk("reset_sum_a", suma, '0);
        chk("reset_sum_b", {32'b0, sumb}, '0);
        chk("reset_sat_b", {303'b0, sb}, '0);
        rst_n = 1'b1;
        idle(1);

        issue(rep_in(1), rep_a(4), 1'b0, rep_b(4), 1'b0);
        idle(4);
        issue(rep_in(-65536), rep_a(-262144), 1'b0, rep_b(-65536), 1'b1);
        issue(rep_in(65535), rep_a(262140), 1'b0, rep_b(65535), 1'b1);
        issue(d_ramp, e_ramp_a, 1'b0, e_ramp_b, 1'b0);
        issue(d_edge, rep_a(65535), 1'b0, rep_b(65535), 1'b0);
        issue(rep_in(-16384), rep_a(-65536), 1'b0, rep_b(-65536), 1'b0);
        idle(5);

        issue(rep_in(1), rep_a(4), 1'b0, rep_b(4), 1'b0);
        issue(rep_in(2), rep_a(8), 1'b0, rep_b(8), 1'b0);
        en = 1'b0;
        in_valid = 1'b1;
        data_in = rep_in(7);
        idle(2);
        in_valid = 1'b0;
        en = 1'b1;
        issue(rep_in(3), rep_a(12), 1'b0, rep_b(12), 1'b0);
        idle(6);

        issue(rep_in(5), rep_a(20), 1'b0, rep_b(20), 1'b0);
        issue(rep_in(6), rep_a(24), 1'b0, rep_b(24), 1'b0);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        idle(1);
        chk("flush_valid_a", {303'b0, va}, '0);
        chk("flush_sum_a", suma, '0);
        chk("flush_valid_b", {303'b0, vb}, '0);
        chk("flush_sum_b", {32'b0, sumb}, '0);
        rst_n = 1'b1;
        idle(6);

        issue(rep_in(-1), rep_a(-4), 1'b0, rep_b(-4), 1'b0);
        for (int k = 0; k < 20 && (qa.size() + qb.size()) != 0; k++) idle(1);
        idle(2);
        chk("drain", (NO*19)'(qa.size() + qb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
